sr_crypto: RTL and testbench
============================

# sr_crypto

Multi-cycle scalar-crypto execute unit for the schoolRISCV core, sitting directly downstream of `sr_control`. While the control FSM holds the PC, it captures the operands, the byte-select field and the decoded `cryptMode`. In the following cycle it presents the 32-bit result that the register file writes through the `WD_SRC_CRYPT` write-data path. It covers the RV32 Zkne/Zknd AES32 instructions and the Zknh SHA-256 and SHA-512 (RV32) instructions.

## Interface
- No parameters; the data width is fixed at 32.
- `clk` in 1 — core clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `cryptStart` in 1 — driven by `sr_control.hold`; high for exactly one cycle per crypto instruction.
- `cryptMode` in 21 — decoded mode from `sr_control`; compared for equality against the `MODE_*` constants.
- `cryptBs` in 2 — byte select, equal to `instr[31:30]`; used by AES32 only.
- `rd1` in 32 — rs1 value from the register file.
- `rd2` in 32 — rs2 value from the register file.
- `cryptResult` out 32 — result presented to the write-data mux.
- `cryptValid` out 1 — result valid; coincides with `sr_control.regWrite` for crypto instructions.

## Operation
- The stage register holds `mode_q`, `bs_q`, `a_q`, `b_q` and `valid_q`.
  - On each posedge where `cryptStart`=1, the register loads the inputs and sets `valid_q`=1.
  - On each posedge where `cryptStart`=0, `valid_q` clears and the data registers hold their values.
- `cryptValid` = `valid_q`.
- `cryptResult` = f(`mode_q`, `a_q`, `b_q`, `bs_q`) when `valid_q`=1; otherwise 32'h0.
- If `mode_q` matches no `MODE_*` constant, the result is 32'h0.
- AES32, with sh = `bs_q`·8 and si = `b_q`[sh+7:sh]:
  - esi: so = Sbox(si); result = `a_q` ^ rol32({24'h0, so}, sh).
  - dsi: same as esi, using InvSbox.
  - esmi: w = {mul3(so), so, so, mul2(so)}; result = `a_q` ^ rol32(w, sh).
  - dsmi: w = {mulB(so), mulD(so), mul9(so), mulE(so)} with InvSbox; result = `a_q` ^ rol32(w, sh).
  - All multiplications are in GF(2^8) modulo x^8+x^4+x^3+x+1.
- SHA-256 operates on `a_q` only:
  - sig0 = ror7 ^ ror18 ^ srl3.
  - sig1 = ror17 ^ ror19 ^ srl10.
  - sum0 = ror2 ^ ror13 ^ ror22.
  - sum1 = ror6 ^ ror11 ^ ror25.
- SHA-512 (RV32) follows the ratified Zknh definitions, with `a_q` as rs1 and `b_q` as rs2:
  - sig0h = a>>1 ^ a>>7 ^ a>>8 ^ b<<31 ^ b<<24.
  - sig0l = sig0h ^ b<<25.
  - sig1h = a<<3 ^ a>>6 ^ a>>19 ^ b>>29 ^ b<<13.
  - sig1l = sig1h ^ b<<26.
  - sum0r = a<<25 ^ a<<30 ^ a>>28 ^ b>>7 ^ b>>2 ^ b<<4.
  - sum1r = a<<23 ^ a>>14 ^ a>>18 ^ b>>9 ^ b<<18 ^ b<<14.
  - All shifts are logical and truncate to 32 bits.
- All arithmetic is unsigned, 32-bit, XOR/shift only; there is no carry.

## Timing
- Reset values:
  - `valid_q`=0, `mode_q`=0, `bs_q`=0, `a_q`=0, `b_q`=0.
  - Therefore `cryptValid`=0 and `cryptResult`=0 during and after reset.
- Latency is one cycle:
  - Cycle T0: `cryptStart`=1; operands are sampled at the end of T0.
  - Cycle T1: `cryptValid`=1 and `cryptResult` is stable for the whole cycle.
  - Cycle T2: `cryptValid`=0.
- The result path from the stage registers to `cryptResult` is purely combinational.
  - It fits one cycle: S-box inversion plus at most 6 XOR levels.
- Back-to-back `cryptStart` (two consecutive cycles) is legal.
  - Each edge re-captures the inputs and `cryptValid` stays high.
  - The result always reflects the most recent capture.
- `rd1`/`rd2` change while `cryptStart`=0: there is no effect on `cryptResult`.
- Reset asserted mid-operation (in T1): `cryptValid` drops immediately (asynchronously) and `cryptResult` reads 0.
- The block stalls nothing itself; stalling is owned by `sr_control`.

## Structure
- Shared header `sr_cpu.vh` holds:
  - the `MODE_*` constants (already defined there);
  - `WD_SRC_CRYPT`;
  - a new `AES_POLY` = 8'h1B.
- Sub-module `sr_aes_sbox` provides forward/inverse S-box as GF(2^8) inversion plus the affine and inverse-affine transforms.
  - Ports: `in[7:0]`, `inv`, `out[7:0]`.
  - It is combinational; no lookup ROM.
- `sr_crypto` instantiates one `sr_aes_sbox`, the stage register, and the SHA/AES result mux.
- Integration: `sr_cpu` connects `sr_control.hold` → `cryptStart` and `cryptResult` → the `WD_SRC_CRYPT` input of the wd mux.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → `cryptValid`=0 and `cryptResult`=32'h0; both hold for the first cycle after release.
- SHA-256 sig0 and sum0:
  - sig0 with `rd1`=32'h00000001 → T1 result 32'h02004000, `cryptValid`=1 for exactly one cycle.
  - sum0 with the same operand → 32'h40080400.
- AES32 esi:
  - `rd1`=0, `rd2`=0, bs=0 → 32'h00000063.
  - bs=3 → 32'h63000000.
  - esmi, bs=0 → 32'hA56363C6.
- AES32 dsi: `rd1`=32'h12345678, `rd2`=32'h00000063, bs=0 → 32'h12345678.
- Back-to-back and hold-off:
  - Two consecutive starts (sig0 on 1, then sum0 on 1) → results 32'h02004000 then 32'h40080400 on consecutive cycles.
  - Changing `rd1` after the start leaves the result unchanged.
- Reset mid-op: pulse `rst_n` low during T1 → `cryptValid` falls within the same cycle; the next start behaves normally.

Source files
------------

// File: rtl/sr_crypto_pkg.sv
// sr_crypto_pkg
//   Shared definitions for the scalar-crypto execute unit: the decoded
//   cryptMode encodings, the write-data mux select used for crypto results,
//   the AES field polynomial and small GF(2^8) / rotate helper functions.
//   No ports; imported by sr_crypto and sr_aes_sbox.

package sr_crypto_pkg;

  localparam int MODE_W = 21;

  // One-hot decode of the crypto instructions as produced by sr_control.
  localparam logic [MODE_W-1:0] MODE_AES32ESI    = 21'h000001;
  localparam logic [MODE_W-1:0] MODE_AES32ESMI   = 21'h000002;
  localparam logic [MODE_W-1:0] MODE_AES32DSI    = 21'h000004;
  localparam logic [MODE_W-1:0] MODE_AES32DSMI   = 21'h000008;
  localparam logic [MODE_W-1:0] MODE_SHA256SIG0  = 21'h000010;
  localparam logic [MODE_W-1:0] MODE_SHA256SIG1  = 21'h000020;
  localparam logic [MODE_W-1:0] MODE_SHA256SUM0  = 21'h000040;
  localparam logic [MODE_W-1:0] MODE_SHA256SUM1  = 21'h000080;
  localparam logic [MODE_W-1:0] MODE_SHA512SIG0H = 21'h000100;
  localparam logic [MODE_W-1:0] MODE_SHA512SIG0L = 21'h000200;
  localparam logic [MODE_W-1:0] MODE_SHA512SIG1H = 21'h000400;
  localparam logic [MODE_W-1:0] MODE_SHA512SIG1L = 21'h000800;
  localparam logic [MODE_W-1:0] MODE_SHA512SUM0R = 21'h001000;
  localparam logic [MODE_W-1:0] MODE_SHA512SUM1R = 21'h002000;

  // Write-data mux select that routes cryptResult into the register file.
  localparam logic [2:0] WD_SRC_CRYPT = 3'd4;

  // Low byte of the AES reduction polynomial x^8+x^4+x^3+x+1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] gfXtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = gfXtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Rotate left by 8*bs, the placement rotation used by every AES32 op.
  function automatic logic [31:0] rolBytes(input logic [31:0] w, input logic [1:0] bs);
    logic [31:0] r;
    case (bs)
      2'd0:    r = w;
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[7:0],  w[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sr_crypto_sbox.sv
// sr_aes_sbox
//   Combinational AES forward / inverse S-box built from GF(2^8) inversion
//   (x^254) plus the affine or inverse-affine transform; no lookup ROM.
//   Ports:
//     in  [7:0]  byte to substitute
//     inv        0 = forward S-box, 1 = inverse S-box
//     out [7:0]  substituted byte

module sr_aes_sbox
  import sr_crypto_pkg::*;
(
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  logic [7:0] invAffineOut;
  logic [7:0] invIn;
  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, x254;
  logic [7:0] fwdAffineOut;

  // The inverse S-box undoes the affine step before inverting, so the
  // inverse-affine transform sits in front of the shared inverter.
  assign invAffineOut = rol8(in, 1) ^ rol8(in, 3) ^ rol8(in, 6) ^ 8'h05;
  assign invIn        = inv ? invAffineOut : in;

  // Multiplicative inverse as invIn^254 via an addition chain; 0 maps to 0.
  assign x2   = gfMul(invIn, invIn);
  assign x3   = gfMul(x2, invIn);
  assign x6   = gfMul(x3, x3);
  assign x12  = gfMul(x6, x6);
  assign x14  = gfMul(x12, x2);
  assign x15  = gfMul(x12, x3);
  assign x30  = gfMul(x15, x15);
  assign x60  = gfMul(x30, x30);
  assign x120 = gfMul(x60, x60);
  assign x240 = gfMul(x120, x120);
  assign x254 = gfMul(x240, x14);

  assign fwdAffineOut = x254 ^ rol8(x254, 1) ^ rol8(x254, 2) ^ rol8(x254, 3)
                      ^ rol8(x254, 4) ^ 8'h63;

  assign out = inv ? x254 : fwdAffineOut;

endmodule

// File: rtl/sr_crypto.sv
// sr_crypto
//   One-cycle scalar-crypto execute unit (AES32 Zkne/Zknd, SHA-256 and
//   SHA-512 RV32 Zknh). Operands are captured on the start cycle and the
//   result is driven combinationally from the stage register in the next.
//   Ports:
//     clk          core clock
//     rst_n        asynchronous active-low reset
//     cryptStart   one-cycle start pulse (sr_control.hold)
//     cryptMode    decoded one-hot mode, see sr_crypto_pkg MODE_*
//     cryptBs      AES32 byte select (instr[31:30])
//     rd1, rd2     rs1 / rs2 operand values
//     cryptResult  result for the WD_SRC_CRYPT write-data path, 0 when idle
//     cryptValid   result valid, high the cycle after cryptStart

module sr_crypto
  import sr_crypto_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cryptStart,
  input  logic [MODE_W-1:0] cryptMode,
  input  logic [1:0]        cryptBs,
  input  logic [31:0]       rd1,
  input  logic [31:0]       rd2,
  output logic [31:0]       cryptResult,
  output logic              cryptValid
);

  logic [MODE_W-1:0] modeQ;
  logic [1:0]        bsQ;
  logic [31:0]       aQ;
  logic [31:0]       bQ;
  logic              validQ;

  logic [7:0]  sboxIn;
  logic [7:0]  so;
  logic        sboxInv;
  logic [31:0] aesEsi;
  logic [31:0] aesEsmi;
  logic [31:0] aesDsmi;
  logic [31:0] rawResult;

  // Stage register: the data fields only load on a start so they keep the
  // last operands; valid is a pure one-cycle echo of the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modeQ  <= '0;
      bsQ    <= 2'd0;
      aQ     <= 32'h0;
      bQ     <= 32'h0;
      validQ <= 1'b0;
    end else begin
      validQ <= cryptStart;
      if (cryptStart) begin
        modeQ <= cryptMode;
        bsQ   <= cryptBs;
        aQ    <= rd1;
        bQ    <= rd2;
      end
    end
  end

  // Pick the selected byte of rs2 for the single shared S-box.
  always_comb begin
    case (bsQ)
      2'd0:    sboxIn = bQ[7:0];
      2'd1:    sboxIn = bQ[15:8];
      2'd2:    sboxIn = bQ[23:16];
      default: sboxIn = bQ[31:24];
    endcase
  end

  assign sboxInv = (modeQ == MODE_AES32DSI) || (modeQ == MODE_AES32DSMI);

  sr_aes_sbox uSbox (
    .in  (sboxIn),
    .inv (sboxInv),
    .out (so)
  );

  // The S-box output is interpreted as forward or inverse depending on the
  // mode, so one column word per MixColumns direction is enough.
  assign aesEsi  = {24'h0, so};
  assign aesEsmi = {gfMul(so, 8'h03), so, so, gfXtime(so)};
  assign aesDsmi = {gfMul(so, 8'h0B), gfMul(so, 8'h0D),
                    gfMul(so, 8'h09), gfMul(so, 8'h0E)};

  // Result mux over all modes; unknown encodings fall through to zero.
  always_comb begin
    rawResult = 32'h0;
    case (modeQ)
      MODE_AES32ESI,
      MODE_AES32DSI:    rawResult = aQ ^ rolBytes(aesEsi, bsQ);
      MODE_AES32ESMI:   rawResult = aQ ^ rolBytes(aesEsmi, bsQ);
      MODE_AES32DSMI:   rawResult = aQ ^ rolBytes(aesDsmi, bsQ);
      MODE_SHA256SIG0:  rawResult = ror32(aQ, 7)  ^ ror32(aQ, 18) ^ (aQ >> 3);
      MODE_SHA256SIG1:  rawResult = ror32(aQ, 17) ^ ror32(aQ, 19) ^ (aQ >> 10);
      MODE_SHA256SUM0:  rawResult = ror32(aQ, 2)  ^ ror32(aQ, 13) ^ ror32(aQ, 22);
      MODE_SHA256SUM1:  rawResult = ror32(aQ, 6)  ^ ror32(aQ, 11) ^ ror32(aQ, 25);
      MODE_SHA512SIG0H: rawResult = (aQ >> 1) ^ (aQ >> 7) ^ (aQ >> 8)
                                  ^ (bQ << 31) ^ (bQ << 24);
      MODE_SHA512SIG0L: rawResult = (aQ >> 1) ^ (aQ >> 7) ^ (aQ >> 8)
                                  ^ (bQ << 31) ^ (bQ << 25) ^ (bQ << 24);
      MODE_SHA512SIG1H: rawResult = (aQ << 3) ^ (aQ >> 6) ^ (aQ >> 19)
                                  ^ (bQ >> 29) ^ (bQ << 13);
      MODE_SHA512SIG1L: rawResult = (aQ << 3) ^ (aQ >> 6) ^ (aQ >> 19)
                                  ^ (bQ >> 29) ^ (bQ << 26) ^ (bQ << 13);
      MODE_SHA512SUM0R: rawResult = (aQ << 25) ^ (aQ << 30) ^ (aQ >> 28)
                                  ^ (bQ >> 7) ^ (bQ >> 2) ^ (bQ << 4);
      MODE_SHA512SUM1R: rawResult = (aQ << 23) ^ (aQ >> 14) ^ (aQ >> 18)
                                  ^ (bQ >> 9) ^ (bQ << 18) ^ (bQ << 14);
      default:          rawResult = 32'h0;
    endcase
  end

  assign cryptValid  = validQ;
  assign cryptResult = validQ ? rawResult : 32'h0;

endmodule

// File: tb/tb_sr_crypto.sv
// tb_sr_crypto
//   Directed testbench for sr_crypto with hand-computed expected results.

module tb_sr_crypto;
  import sr_crypto_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cryptStart;
  logic [MODE_W-1:0] cryptMode;
  logic [1:0]        cryptBs;
  logic [31:0]       rd1;
  logic [31:0]       rd2;
  logic [31:0]       cryptResult;
  logic              cryptValid;

  int checks = 0;
  int errors = 0;

  sr_crypto dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cryptStart  (cryptStart),
    .cryptMode   (cryptMode),
    .cryptBs     (cryptBs),
    .rd1         (rd1),
    .rd2         (rd2),
    .cryptResult (cryptResult),
    .cryptValid  (cryptValid)
  );

  always #5 clk = ~clk;

  // Drive one set of inputs on the falling edge, away from the capture edge.
  task automatic applyStimulus(input logic start, input logic [MODE_W-1:0] mode,
                               input logic [1:0] bs, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk);
    cryptStart = start;
    cryptMode  = mode;
    cryptBs    = bs;
    rd1        = a;
    rd2        = b;
  endtask

  // Advance past the next rising edge and settle.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Start one op, check its T1 result/valid, then check valid drops in T2.
  task automatic runOp(input string tag, input logic [MODE_W-1:0] mode,
                       input logic [1:0] bs, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(1'b1, mode, bs, a, b);
    stepCycle();
    checkOutput({tag, "_valid"}, {31'b0, cryptValid}, 32'h1);
    checkOutput({tag, "_result"}, cryptResult, expected);
    applyStimulus(1'b0, mode, bs, a, b);
    stepCycle();
    checkOutput({tag, "_validT2"}, {31'b0, cryptValid}, 32'h0);
  endtask

  initial begin
    // Reset with random inputs, start included, must keep everything idle.
    rst_n      = 1'b0;
    cryptStart = 1'b1;
    cryptMode  = MODE_SHA256SIG0;
    cryptBs    = 2'($urandom_range(3));
    rd1        = $urandom;
    rd2        = $urandom;
    repeat (2) stepCycle();
    checkOutput("reset_valid", {31'b0, cryptValid}, 32'h0);
    checkOutput("reset_result", cryptResult, 32'h0);
    @(negedge clk);
    cryptStart = 1'b0;
    rst_n      = 1'b1;
    stepCycle();
    checkOutput("postreset_valid", {31'b0, cryptValid}, 32'h0);
    checkOutput("postreset_result", cryptResult, 32'h0);

    // SHA-256
    runOp("sig0", MODE_SHA256SIG0, 2'd0, 32'h00000001, 32'h0, 32'h02004000);
    runOp("sum0", MODE_SHA256SUM0, 2'd0, 32'h00000001, 32'h0, 32'h40080400);
    runOp("sig1", MODE_SHA256SIG1, 2'd0, 32'h00000001, 32'h0, 32'h0000A000);
    runOp("sum1", MODE_SHA256SUM1, 2'd0, 32'h00000001, 32'h0, 32'h04200080);

    // AES32
    runOp("esi_bs0", MODE_AES32ESI, 2'd0, 32'h0, 32'h0, 32'h00000063);
    runOp("esi_bs3", MODE_AES32ESI, 2'd3, 32'h0, 32'h0, 32'h63000000);
    runOp("esmi_bs0", MODE_AES32ESMI, 2'd0, 32'h0, 32'h0, 32'hA56363C6);
    runOp("dsi_bs0", MODE_AES32DSI, 2'd0, 32'h12345678, 32'h00000063, 32'h12345678);
    runOp("dsmi_bs0", MODE_AES32DSMI, 2'd0, 32'h0, 32'h0, 32'h50A7F451);

    // SHA-512 RV32
    runOp("sig0h", MODE_SHA512SIG0H, 2'd0, 32'h0, 32'h00000001, 32'h81000000);
    runOp("sig0l", MODE_SHA512SIG0L, 2'd0, 32'h0, 32'h00000001, 32'h83000000);
    runOp("sig1h", MODE_SHA512SIG1H, 2'd0, 32'h00000001, 32'h0, 32'h00000008);
    runOp("sum0r", MODE_SHA512SUM0R, 2'd0, 32'h80000000, 32'h0, 32'h00000008);

    // Unknown mode yields zero while still valid.
    runOp("badmode", 21'h100000, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);

    // Back-to-back starts: each edge recaptures, valid stays high.
    applyStimulus(1'b1, MODE_SHA256SIG0, 2'd0, 32'h00000001, 32'h0);
    stepCycle();
    checkOutput("b2b_first", cryptResult, 32'h02004000);
    applyStimulus(1'b1, MODE_SHA256SUM0, 2'd0, 32'h00000001, 32'h0);
    stepCycle();
    checkOutput("b2b_valid", {31'b0, cryptValid}, 32'h1);
    checkOutput("b2b_second", cryptResult, 32'h40080400);

    // Operand changes with start low must not disturb the held result.
    applyStimulus(1'b1, MODE_SHA256SIG0, 2'd0, 32'h00000001, 32'h0);
    stepCycle();
    cryptStart = 1'b0;
    rd1        = 32'hFFFFFFFF;
    rd2        = 32'hFFFFFFFF;
    #2;
    checkOutput("holdoff_result", cryptResult, 32'h02004000);
    stepCycle();
    checkOutput("holdoff_validT2", {31'b0, cryptValid}, 32'h0);

    // Reset asserted during T1 clears valid and result immediately.
    applyStimulus(1'b1, MODE_SHA256SIG0, 2'd0, 32'h00000001, 32'h0);
    stepCycle();
    checkOutput("midrst_pre", {31'b0, cryptValid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, cryptValid}, 32'h0);
    checkOutput("midrst_result", cryptResult, 32'h0);
    @(negedge clk);
    cryptStart = 1'b0;
    rst_n      = 1'b1;
    runOp("afterrst", MODE_SHA256SUM0, 2'd0, 32'h00000001, 32'h0, 32'h40080400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
